core_ctrl_fsm: RTL and testbench

CORE_CTRL_FSM -- requirements
Module: core_ctrl_fsm

---
 rtl/core_ctrl_fsm_if.sv | 31 +++
 rtl/core_ctrl_fsm.sv | 139 +++++++++++++
 tb/tb_core_ctrl_fsm.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_fsm_if.sv
// Control/handshake bundle between the multi-cycle core controller and its datapath/memories.
// The controller side takes the master modport; the datapath/memory side takes slave.
interface core_ctrl_fsm_if;
    logic [7:0]  class_i;
    logic        imem_valid_i;
    logic        dmem_ready_i;
    logic        branch_taken_i;
    logic        imem_req_o;
    logic        ir_we_o;
    logic        pc_we_o;
    logic [1:0]  pc_sel_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        rf_we_o;
    logic [1:0]  wb_sel_o;
    logic        illegal_o;
    logic [2:0]  state_o;
    logic [31:0] instret_o;

    modport master (
        input  class_i, imem_valid_i, dmem_ready_i, branch_taken_i,
        output imem_req_o, ir_we_o, pc_we_o, pc_sel_o, dmem_req_o, dmem_we_o,
               rf_we_o, wb_sel_o, illegal_o, state_o, instret_o
    );

    modport slave (
        output class_i, imem_valid_i, dmem_ready_i, branch_taken_i,
        input  imem_req_o, ir_we_o, pc_we_o, pc_sel_o, dmem_req_o, dmem_we_o,
               rf_we_o, wb_sel_o, illegal_o, state_o, instret_o
    );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle core sequencer: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) with a sticky TRAP state.
// Strobes are decoded from the current state and live handshake inputs so they act in the same cycle.
module core_ctrl_fsm (
    input  logic                   clk_i,
    input  logic                   rst_i,
    core_ctrl_fsm_if.master        bus
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_e;

    localparam int C_RTYPE  = 0;
    localparam int C_ITYPE  = 1;
    localparam int C_STORE  = 2;
    localparam int C_BRANCH = 3;
    localparam int C_LOAD   = 4;
    localparam int C_JALR   = 5;
    localparam int C_JAL    = 6;
    localparam int C_LUI    = 7;

    state_e      state_q, state_d;
    logic [7:0]  class_q;
    logic [31:0] instret_q;

    logic        imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we;
    logic [1:0]  pc_sel, wb_sel;
    logic        class_onehot;

    assign class_onehot = (bus.class_i != 8'd0) &&
                          ((bus.class_i & (bus.class_i - 8'd1)) == 8'd0);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_valid_i) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = class_onehot ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (class_q[C_BRANCH]) begin
                    pc_we   = 1'b1;
                    pc_sel  = bus.branch_taken_i ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else if (class_q[C_LOAD] || class_q[C_STORE]) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = class_q[C_STORE];
                if (bus.dmem_ready_i) begin
                    if (class_q[C_STORE]) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                if (class_q[C_LOAD])                          wb_sel = 2'b01;
                else if (class_q[C_JAL] || class_q[C_JALR])   wb_sel = 2'b10;
                else if (class_q[C_LUI])                      wb_sel = 2'b11;
                else if (class_q[C_RTYPE] || class_q[C_ITYPE]) wb_sel = 2'b00;
                if (class_q[C_JAL])       pc_sel = 2'b01;
                else if (class_q[C_JALR]) pc_sel = 2'b10;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        // Reset silences every strobe immediately, even before the first reset edge lands.
        if (rst_i) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 2'b00;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            class_q   <= 8'd0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                class_q <= bus.class_i;
            end
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign bus.imem_req_o = imem_req;
    assign bus.ir_we_o    = ir_we;
    assign bus.pc_we_o    = pc_we;
    assign bus.pc_sel_o   = pc_sel;
    assign bus.dmem_req_o = dmem_req;
    assign bus.dmem_we_o  = dmem_we;
    assign bus.rf_we_o    = rf_we;
    assign bus.wb_sel_o   = wb_sel;
    assign bus.illegal_o  = (state_q == S_TRAP) && !rst_i;
    assign bus.state_o    = rst_i ? 3'd0 : state_q;
    assign bus.instret_o  = rst_i ? 32'd0 : instret_q;
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed, table-driven bench for core_ctrl_fsm; one vector per clock cycle, outputs sampled mid-cycle.
module tb_core_ctrl_fsm;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    core_ctrl_fsm_if bus_if ();
    core_ctrl_fsm dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_if));

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

    typedef struct {
        logic        rst;
        logic [7:0]  cls;
        logic        iv, dr, bt;
        logic [13:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    // ctl = {state, imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, rf_we, wb_sel, illegal}
    task automatic vec(input logic rst, input logic [7:0] cls, input logic iv, input logic dr,
                       input logic bt, input logic [2:0] st, input logic ireq, input logic irwe,
                       input logic pcwe, input logic [1:0] psel, input logic dreq, input logic dwe,
                       input logic rfwe, input logic [1:0] wsel, input logic ill,
                       input logic [31:0] cnt);
        vec_t e;
        e.rst = rst; e.cls = cls; e.iv = iv; e.dr = dr; e.bt = bt;
        e.ctl = {st, ireq, irwe, pcwe, psel, dreq, dwe, rfwe, wsel, ill};
        e.cnt = cnt;
        vecs.push_back(e);
    endtask

    function automatic logic [13:0] act_ctl();
        return {bus_if.state_o, bus_if.imem_req_o, bus_if.ir_we_o, bus_if.pc_we_o,
                bus_if.pc_sel_o, bus_if.dmem_req_o, bus_if.dmem_we_o, bus_if.rf_we_o,
                bus_if.wb_sel_o, bus_if.illegal_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        bus_if.class_i = 8'd0;
        bus_if.imem_valid_i = 1'b0;
        bus_if.dmem_ready_i = 1'b0;
        bus_if.branch_taken_i = 1'b0;

        // reset: everything quiet, handshakes ignored
        vec(1, 8'h01, 1, 1, 1, F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 8'h01, 1, 0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // r-type
        vec(0, 8'h01, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h01, 1, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h01, 0, 0, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h01, 0, 0, 0, W, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        vec(0, 8'h01, 0, 0, 0, F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // load with two wait cycles
        vec(0, 8'h10, 1, 1, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        vec(0, 8'h10, 0, 1, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vec(0, 8'h10, 0, 0, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vec(0, 8'h10, 0, 0, 0, M, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        vec(0, 8'h10, 0, 0, 0, M, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        vec(0, 8'h10, 0, 1, 0, M, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        vec(0, 8'h10, 0, 0, 0, W, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1);
        // store, ready already high in EXECUTE
        vec(0, 8'h04, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        vec(0, 8'h04, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        vec(0, 8'h04, 0, 1, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        vec(0, 8'h04, 0, 1, 0, M, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2);
        // branch taken then not taken
        vec(0, 8'h08, 1, 0, 1, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        vec(0, 8'h08, 0, 0, 1, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vec(0, 8'h08, 0, 0, 1, E, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3);
        vec(0, 8'h08, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4);
        vec(0, 8'h08, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        vec(0, 8'h08, 0, 0, 0, E, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4);
        // jalr
        vec(0, 8'h20, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5);
        vec(0, 8'h20, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        vec(0, 8'h20, 0, 0, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        vec(0, 8'h20, 0, 0, 0, W, 0, 0, 1, 2, 0, 0, 1, 2, 0, 5);
        // jal, class_i changed after DECODE must not matter
        vec(0, 8'h40, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 6);
        vec(0, 8'h40, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        vec(0, 8'h01, 0, 0, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        vec(0, 8'h01, 0, 0, 0, W, 0, 0, 1, 1, 0, 0, 1, 2, 0, 6);
        // lui
        vec(0, 8'h80, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7);
        vec(0, 8'h80, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        vec(0, 8'h80, 0, 0, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        vec(0, 8'h80, 0, 0, 0, W, 0, 0, 1, 0, 0, 0, 1, 3, 0, 7);
        // i-type
        vec(0, 8'h02, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        vec(0, 8'h02, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
        vec(0, 8'h02, 0, 0, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
        vec(0, 8'h02, 0, 0, 0, W, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8);
        // load interrupted by reset while waiting in MEM
        vec(0, 8'h10, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 9);
        vec(0, 8'h10, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        vec(0, 8'h10, 0, 0, 0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        vec(0, 8'h10, 0, 0, 0, M, 0, 0, 0, 0, 1, 0, 0, 0, 0, 9);
        vec(1, 8'h10, 0, 0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h10, 0, 0, 0, F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // multi-hot class traps and stays trapped
        vec(0, 8'h03, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h03, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h03, 1, 1, 1, T, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vec(0, 8'h01, 1, 1, 1, T, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vec(1, 8'h00, 0, 0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // zero class traps
        vec(0, 8'h00, 1, 0, 0, F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h00, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h00, 0, 0, 0, T, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vec(1, 8'h00, 0, 0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 8'h00, 0, 0, 0, F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            rst_i                 = vecs[i].rst;
            bus_if.class_i        = vecs[i].cls;
            bus_if.imem_valid_i   = vecs[i].iv;
            bus_if.dmem_ready_i   = vecs[i].dr;
            bus_if.branch_taken_i = vecs[i].bt;
            #1;
            $display("vec %0d rst=%0d cls=%h st=%0d ctl=%h instret=%0d", i, vecs[i].rst,
                     vecs[i].cls, bus_if.state_o, act_ctl(), bus_if.instret_o);
            check($sformatf("vec%0d_ctl", i), {18'd0, act_ctl()}, {18'd0, vecs[i].ctl});
            check($sformatf("vec%0d_instret", i), bus_if.instret_o, vecs[i].cnt);
        end

        // instret wrap: preload near the top, then retire one branch
        bus_if.imem_valid_i = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk_i);
        release dut.instret_q;
        #1;
        check("wrap_preload", bus_if.instret_o, 32'hFFFF_FFFF);
        bus_if.class_i = 8'h08;
        bus_if.branch_taken_i = 1'b1;
        bus_if.imem_valid_i = 1'b1;
        @(negedge clk_i);
        bus_if.imem_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("wrap_exec_pcwe", {31'd0, bus_if.pc_we_o}, 32'd1);
        check("wrap_exec_pcsel", {30'd0, bus_if.pc_sel_o}, 32'd1);
        @(negedge clk_i);
        #1;
        $display("wrap st=%0d instret=%h", bus_if.state_o, bus_if.instret_o);
        check("wrap_instret", bus_if.instret_o, 32'd0);
        check("wrap_state", {29'd0, bus_if.state_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
